// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
// The high-phase length is computed one bit wider than the divisor so N = 2^W-1 cannot overflow.
package clk_div_pkg;

    localparam int unsigned DEF_W   = 8;
    localparam int unsigned DEF_DIV = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // High-phase length ceil(n/2).
    function automatic logic [63:0] hi_of(input logic [63:0] n);
        return (n + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/div_counter.sv
// Period counter for the clock divider: counts 0..n-1 while run is high and
// presents the values the output registers should take at the next edge.
module div_counter
    import clk_div_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] n,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         out_clk_nxt,
    output logic         tick_nxt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] hi;

    assign hi  = W'(hi_of(64'(n)));
    assign cnt = cnt_q;

    // When not running the counter sits at zero, so the *_nxt values already
    // describe the first cycle of a period for a start from IDLE.
    always_comb begin
        wrap  = run && (cnt_q == (n - ONE));
        cnt_d = '0;
        if (run && !wrap) begin
            cnt_d = cnt_q + ONE;
        end
        out_clk_nxt = (cnt_d < hi);
        tick_nxt    = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller: run/drain sequencing and a divisor
// update handshake whose new value only takes effect on a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned W           = DEF_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         out_clk,
    output logic         tick,
    output logic [W-1:0] div_cur,
    output logic         busy,
    output logic         err
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

    state_e       state_q, state_d;
    logic         out_clk_q, out_clk_d;
    logic         tick_q, tick_d;
    logic         busy_q, busy_d;
    logic [W-1:0] div_cur_q, div_cur_d;
    logic [W-1:0] pend_q, pend_d;
    logic         ready_q, ready_d;
    logic         err_q, err_d;

    logic         run;
    logic [W-1:0] cnt;
    logic         wrap;
    logic         out_clk_nxt;
    logic         tick_nxt;
    logic         xfer;
    logic         apply;

    assign run = (state_q != IDLE);

    div_counter #(
        .W(W)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .n           (div_cur_q),
        .cnt         (cnt),
        .wrap        (wrap),
        .out_clk_nxt (out_clk_nxt),
        .tick_nxt    (tick_nxt)
    );

    // ready_q low doubles as "a divisor is pending", so a transfer and an
    // apply can never coincide.
    always_comb begin
        state_d   = state_q;
        out_clk_d = 1'b0;
        tick_d    = 1'b0;
        div_cur_d = div_cur_q;
        pend_d    = pend_q;
        ready_d   = ready_q;
        err_d     = err_q;

        xfer  = div_valid && ready_q;
        apply = !ready_q && ((state_q == IDLE) || wrap);

        if (xfer) begin
            if (div_in == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d  = div_in;
                ready_d = 1'b0;
            end
        end

        if (apply) begin
            div_cur_d = pend_q;
            ready_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RUN;
                    out_clk_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN: begin
                out_clk_d = out_clk_nxt;
                tick_d    = tick_nxt;
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d   = RUN;
                    out_clk_d = out_clk_nxt;
                    tick_d    = tick_nxt;
                end else if (wrap) begin
                    state_d = IDLE;
                end else begin
                    out_clk_d = out_clk_nxt;
                    tick_d    = tick_nxt;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            div_cur_q <= DIV_RST;
            pend_q    <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // The counter must rest at zero whenever the controller is idle.
    assert property (@(posedge clk) disable iff (rst) (state_q != IDLE) || (cnt == '0));

    assign out_clk   = out_clk_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign div_cur   = div_cur_q;
    assign div_ready = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (W=8, DEFAULT_DIV=3).
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_valid;
    logic       div_ready;
    logic       out_clk;
    logic       tick;
    logic [7:0] div_cur;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(
        .W           (8),
        .DEFAULT_DIV (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .out_clk   (out_clk),
        .tick      (tick),
        .div_cur   (div_cur),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        int tick_cnt;

        rst       = 1'b1;
        en        = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;

        // ---- 1: reset state and default divide-by-3 ----
        repeat (2) @(negedge clk);
        check("rst_out_clk", 32'(out_clk), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_div_cur", 32'(div_cur), 3);
        check("rst_ready", 32'(div_ready), 1);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_out_clk", 32'(out_clk), 0);
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("n3_out_clk", 32'(out_clk), ((i % 3) < 2) ? 1 : 0);
            check("n3_tick", 32'(tick), ((i % 3) == 0) ? 1 : 0);
            check("n3_busy", 32'(busy), 1);
        end

        // ---- 2: update to N=4 offered at cnt=1 ----
        @(negedge clk);
        @(negedge clk);
        check("u4_pre_ready", 32'(div_ready), 1);
        div_in    = 8'd4;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        check("u4_ready_low", 32'(div_ready), 0);
        check("u4_old_cur", 32'(div_cur), 3);
        check("u4_last_out", 32'(out_clk), 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("u4_cur", 32'(div_cur), 4);
                check("u4_ready_back", 32'(div_ready), 1);
            end
            check("n4_out_clk", 32'(out_clk), ((j % 4) < 2) ? 1 : 0);
            check("n4_tick", 32'(tick), ((j % 4) == 0) ? 1 : 0);
        end

        // ---- 3: transfer on the wrap edge, N=5, drain and re-enable ----
        div_in    = 8'd5;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        check("wx_cur_held", 32'(div_cur), 4);
        check("wx_ready_low", 32'(div_ready), 0);
        check("wx_tick", 32'(tick), 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("n5_cur", 32'(div_cur), 5);
        check("n5_ready", 32'(div_ready), 1);
        check("n5_tick0", 32'(tick), 1);
        @(negedge clk);
        check("n5_out_c1", 32'(out_clk), 1);
        en = 1'b0;
        @(negedge clk);
        check("dr_out_c2", 32'(out_clk), 1);
        check("dr_busy_c2", 32'(busy), 1);
        check("dr_tick_c2", 32'(tick), 0);
        @(negedge clk);
        check("dr_out_c3", 32'(out_clk), 0);
        @(negedge clk);
        check("dr_out_c4", 32'(out_clk), 0);
        check("dr_busy_c4", 32'(busy), 1);
        @(negedge clk);
        check("dr_idle_out", 32'(out_clk), 0);
        check("dr_idle_tick", 32'(tick), 0);
        check("dr_idle_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_no_tick", 32'(tick), 0);
            check("idle_out_low", 32'(out_clk), 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("rr_tick0", 32'(tick), 1);
        check("rr_busy", 32'(busy), 1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("rr_drain_busy", 32'(busy), 1);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("rr_c4_out", 32'(out_clk), 0);
        check("rr_c4_tick", 32'(tick), 0);
        check("rr_c4_busy", 32'(busy), 1);
        @(negedge clk);
        check("rr_wrap_tick", 32'(tick), 1);
        check("rr_wrap_out", 32'(out_clk), 1);

        // ---- 4: zero divisor sets err, then N=1 ----
        div_in    = 8'd0;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        check("z_err", 32'(err), 1);
        check("z_ready", 32'(div_ready), 1);
        check("z_cur", 32'(div_cur), 5);
        @(negedge clk);
        check("z_err_sticky", 32'(err), 1);
        div_in    = 8'd1;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        check("n1_ready_low", 32'(div_ready), 0);
        @(negedge clk);
        check("n1_cur_held", 32'(div_cur), 5);
        @(negedge clk);
        check("n1_cur", 32'(div_cur), 1);
        check("n1_ready", 32'(div_ready), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("n1_out_clk", 32'(out_clk), 1);
            check("n1_tick", 32'(tick), 1);
        end

        // ---- 5: asynchronous reset with a divisor pending ----
        div_in    = 8'd6;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        check("ar_pre_ready", 32'(div_ready), 0);
        check("ar_pre_out", 32'(out_clk), 1);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("ar_out_clk", 32'(out_clk), 0);
        check("ar_div_cur", 32'(div_cur), 3);
        check("ar_ready", 32'(div_ready), 1);
        check("ar_err", 32'(err), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_tick", 32'(tick), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_pend_gone", 32'(div_cur), 3);
        check("ar_idle_ready", 32'(div_ready), 1);

        // ---- 6: N=255 applied in IDLE ----
        div_in    = 8'd255;
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        check("m_ready_low", 32'(div_ready), 0);
        @(negedge clk);
        check("m_cur", 32'(div_cur), 255);
        check("m_ready", 32'(div_ready), 1);
        en       = 1'b1;
        hi_cnt   = 0;
        tick_cnt = 0;
        for (int k = 0; k < 510; k++) begin
            @(negedge clk);
            if (k < 255 && out_clk === 1'b1) hi_cnt++;
            if (tick === 1'b1) tick_cnt++;
            if (k == 127) check("m_out_127", 32'(out_clk), 1);
            if (k == 128) check("m_out_128", 32'(out_clk), 0);
            if (k == 254) check("m_out_254", 32'(out_clk), 0);
            if (k == 255) begin
                check("m_wrap_tick", 32'(tick), 1);
                check("m_wrap_out", 32'(out_clk), 1);
            end
        end
        check("m_hi_cycles", 32'(hi_cnt), 128);
        check("m_ticks", 32'(tick_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-divider controller. It generates a divided clock `out_clk` and a single-cycle `tick` strobe from `clk`, using a runtime divisor N. Divisor updates arrive over a valid/ready handshake and take effect only at a period boundary, so every output period is complete and glitch-free. Enable/disable is sequenced so that a period in progress always finishes. It sits next to the fixed divide-by-3 block as its programmable, software-controlled counterpart for downstream slow-clock-enable consumers.

Parameters:
- W, 8: width of the divisor and the internal counter.
- DEFAULT_DIV, 3: divisor loaded at reset; must be in 1..2^W-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request.
- div_in  input  W  new divisor N.
- div_valid  input  1  div_in is valid.
- div_ready  output  1  controller can accept a divisor.
- out_clk  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the first cycle of each out_clk period.
- div_cur  output  W  divisor currently in effect.
- busy  output  1  state is not IDLE.
- err  output  1  sticky flag: a divisor of 0 was offered.

Behaviour:
- Reset (asynchronous, any time, including mid-period or with an update pending):
  - state=IDLE, cnt=0, out_clk=0, tick=0, div_cur=DEFAULT_DIV.
  - Pending divisor cleared, div_ready=1, err=0.
- All outputs are registered. HI = (div_cur+1)>>1, i.e. out_clk is high for ceil(N/2) cycles.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - out_clk=0, tick=0, cnt=0.
  - en=1 at edge t → state=RUN at t, with cnt=0, out_clk=1, tick=1 registered at that edge.
- RUN:
  - Each edge: cnt = (cnt==div_cur-1) ? 0 : cnt+1.
  - out_clk = (next cnt < HI); tick = (next cnt == 0).
  - en=0 → DRAIN; the current period keeps running.
- DRAIN:
  - Counts exactly as in RUN.
  - At the wrap edge (cnt==div_cur-1): state=IDLE, out_clk=0, tick=0, cnt=0.
  - en=1 before the wrap edge → back to RUN with no disturbance to the count.
- N=1: out_clk stays at 1 and tick=1 every cycle while RUN.
- Handshake:
  - Transfer happens when div_valid && div_ready.
  - div_in≠0: value latched as pending; div_ready=0 from the next cycle.
  - div_in==0: transfer completes, value is discarded, err=1 (sticky), div_ready stays 1.
- Applying a pending divisor:
  - In RUN/DRAIN: at the wrap edge. div_cur=pending, div_ready=1, and the new period starts with the new N at that same edge (HI uses the new N).
  - In IDLE: applied at the next edge.
- Simultaneous events:
  - Transfer and wrap on the same edge: not possible, since div_ready=0 while pending. A transfer on the wrap edge itself with no pending value is applied at the following wrap.
  - en falling on the wrap edge: the new period still starts, and DRAIN completes it.
- busy = (state != IDLE).

Decomposition:
- Package clk_div_pkg: state enum {IDLE, RUN, DRAIN}, default W, DEFAULT_DIV, HI helper function.
- One natural sub-module, div_counter:
  - Inputs: clk, rst, run, n.
  - Outputs: cnt, wrap, out_clk_nxt, tick_nxt.
  - The FSM and handshake logic stay in clk_div_ctrl.

Test Plan:
1. Reset, then en=1 held for 12 cycles with DEFAULT_DIV=3 → out_clk 1,1,0 repeating; tick on cycles 0,3,6,9; busy=1.
2. In RUN with N=3, offer div_in=4 at cnt=1 → div_ready drops the next cycle; the period ends at cnt=2; then out_clk 1,1,0,0 repeating; div_cur=4 and div_ready=1 at that wrap edge.
3. N=5, drop en at cnt=1 → out_clk finishes 1,1,1,0,0; IDLE after the wrap; busy=0; no tick afterwards. Second run: raise en again at cnt=3 → no IDLE gap, tick at the next wrap.
4. Offer div_in=0 → err=1 sticky; div_cur unchanged; div_ready stays 1. Then div_in=1 → out_clk stays at 1, tick every cycle.
5. Assert rst asynchronously mid-period with a divisor pending → out_clk=0, div_cur=3, div_ready=1, err=0 immediately, without waiting for a clock edge.
6. N=255 (all ones) → period 255 cycles, out_clk high for 128 cycles, counter wraps with no overflow.
